// File: rtl/matrix_capture_if.sv
// Pixel write port of the HUB75 receiver: one (row, column, plane, rgb)
// record per valid/ready handshake.
interface matrix_capture_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [3:0] wr_row;
   logic [5:0] wr_column;
   logic [2:0] wr_plane;
   logic [2:0] wr_rgb1;
   logic [2:0] wr_rgb2;

   modport master (
      output wr_valid, wr_row, wr_column, wr_plane, wr_rgb1, wr_rgb2,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_row, wr_column, wr_plane, wr_rgb1, wr_rgb2,
      output wr_ready
   );
endinterface

// File: rtl/matrix_capture.sv
// HUB75 receiver. Oversamples the panel bus, shifts in one row of pixels per
// latch, measures the following OE pulse to recover the bit plane and replays
// the latched row as COLUMNS pixel writes on the wr port.
module matrix_capture #(
   parameter int COLUMNS      = 64,
   parameter int PLANES       = 6,
   parameter int OE_UNIT_LOG2 = 0
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             hub_clk,
   input  logic             hub_latch,
   input  logic             hub_oe,
   input  logic [3:0]       hub_addr,
   input  logic [2:0]       hub_rgb1,
   input  logic [2:0]       hub_rgb2,
   matrix_capture_if.master wr,
   output logic             err_count,
   output logic             err_overrun,
   output logic             err_runt,
   input  logic             clear_err
);

   typedef struct packed {
      logic       clk;
      logic       latch;
      logic       oe;
      logic [3:0] addr;
      logic [2:0] rgb1;
      logic [2:0] rgb2;
   } hub_t;

   typedef enum logic [1:0] {IDLE, WAIT_OE, MEASURE, EMIT} state_t;

   localparam logic [6:0] COUNT_FULL = 7'(COLUMNS);
   localparam logic [5:0] COL_LAST   = 6'(COLUMNS - 1);
   localparam logic [3:0] PLANE_MAX  = 4'(PLANES - 1);

   hub_t        hub_in, meta_q, meta_d, sync_q, sync_d;
   logic [2:0]  hist_q, hist_d;            // {clk, latch, oe} one cycle behind sync_q
   state_t      state_q, state_d;
   logic [6:0]  pix_cnt_q, pix_cnt_d, shift_idx;
   logic [5:0]  shift_q [COLUMNS];
   logic [5:0]  shift_d [COLUMNS];
   logic [5:0]  hold_q  [COLUMNS];
   logic [5:0]  hold_d  [COLUMNS];
   logic [15:0] oe_width_q, oe_width_d, units;
   logic [3:0]  row_q, row_d, units_msb;
   logic [2:0]  plane_q, plane_d, plane_dec;
   logic [5:0]  col_q, col_d;
   logic        err_count_q, err_count_d, err_overrun_q, err_overrun_d, err_runt_q, err_runt_d;
   logic        clk_rise, latch_rise, oe_rise, oe_fall;
   logic        latch_ok, count_set, overrun_set, runt_set;

   assign hub_in     = {hub_clk, hub_latch, hub_oe, hub_addr, hub_rgb1, hub_rgb2};
   assign clk_rise   = sync_q.clk   & ~hist_q[2];
   assign latch_rise = sync_q.latch & ~hist_q[1];
   assign oe_rise    = sync_q.oe    & ~hist_q[0];
   assign oe_fall    = ~sync_q.oe   &  hist_q[0];

   // Two-flop synchronizer plus edge-history stage for the whole HUB75 bus.
   always_comb begin
      meta_d = hub_in;
      sync_d = meta_q;
      hist_d = {sync_q.clk, sync_q.latch, sync_q.oe};
   end

   // Shift side: pixel capture on hub_clk rises, row hand-off on hub_latch rises.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves it
      // unassigned and no latch is inferred.
      shift_d     = shift_q;
      hold_d      = hold_q;
      pix_cnt_d   = pix_cnt_q;
      shift_idx   = pix_cnt_q;
      latch_ok    = 1'b0;
      count_set   = 1'b0;
      overrun_set = 1'b0;
      if (latch_rise) begin
         pix_cnt_d = '0;
         shift_idx = '0;
         if (pix_cnt_q != COUNT_FULL) begin
            count_set = 1'b1;
         end else if (state_q != IDLE) begin
            overrun_set = 1'b1;
         end else begin
            latch_ok = 1'b1;
            hold_d   = shift_q;
         end
      end
      // A pixel arriving with the latch is the first pixel of the next row.
      if (clk_rise && shift_idx < COUNT_FULL) begin
         shift_d[shift_idx[5:0]] = {sync_q.rgb1, sync_q.rgb2};
         pix_cnt_d               = shift_idx + 7'd1;
      end
   end

   // Plane decode: floor(log2(units)) - 1, clamped to the top plane.
   always_comb begin
      units     = oe_width_q >> OE_UNIT_LOG2;
      units_msb = '0;
      for (int i = 1; i < 16; i++) begin
         if (units[i]) units_msb = 4'(i);
      end
      plane_dec = (units_msb - 4'd1 > PLANE_MAX) ? PLANE_MAX[2:0] : 3'(units_msb - 4'd1);
   end

   // Control FSM: wait for OE, measure its width, then replay the held row.
   always_comb begin
      state_d    = state_q;
      oe_width_d = oe_width_q;
      row_d      = row_q;
      plane_d    = plane_q;
      col_d      = col_q;
      runt_set   = 1'b0;
      case (state_q)
         IDLE: begin
            if (latch_ok) state_d = WAIT_OE;
         end
         WAIT_OE: begin
            if (oe_rise) begin
               state_d    = MEASURE;
               oe_width_d = 16'd1;
            end
         end
         MEASURE: begin
            if (oe_width_q == 16'd1) row_d = sync_q.addr;
            if (oe_fall) begin
               if (units < 16'd2) begin
                  runt_set = 1'b1;
                  state_d  = IDLE;
               end else begin
                  plane_d = plane_dec;
                  col_d   = '0;
                  state_d = EMIT;
               end
            end else if (sync_q.oe && oe_width_q != 16'hFFFF) begin
               oe_width_d = oe_width_q + 16'd1;
            end
         end
         EMIT: begin
            if (wr.wr_ready) begin
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  state_d = IDLE;
               end else begin
                  col_d = col_q + 6'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sticky errors; clear_err overrides a same-cycle set.
   always_comb begin
      err_count_d   = clear_err ? 1'b0 : (err_count_q   | count_set);
      err_overrun_d = clear_err ? 1'b0 : (err_overrun_q | overrun_set);
      err_runt_d    = clear_err ? 1'b0 : (err_runt_q    | runt_set);
   end

   // State register for the whole block.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         meta_q        <= '0;
         sync_q        <= '0;
         hist_q        <= '0;
         state_q       <= IDLE;
         pix_cnt_q     <= '0;
         // NOTE: both pixel buffers are reset on purpose: wr_rgb reads the holding
         // buffer directly and a reset must drop any pending row and show zeros.
         shift_q       <= '{default: '0};
         hold_q        <= '{default: '0};
         oe_width_q    <= '0;
         row_q         <= '0;
         plane_q       <= '0;
         col_q         <= '0;
         err_count_q   <= 1'b0;
         err_overrun_q <= 1'b0;
         err_runt_q    <= 1'b0;
      end else begin
         meta_q        <= meta_d;
         sync_q        <= sync_d;
         hist_q        <= hist_d;
         state_q       <= state_d;
         pix_cnt_q     <= pix_cnt_d;
         shift_q       <= shift_d;
         hold_q        <= hold_d;
         oe_width_q    <= oe_width_d;
         row_q         <= row_d;
         plane_q       <= plane_d;
         col_q         <= col_d;
         err_count_q   <= err_count_d;
         err_overrun_q <= err_overrun_d;
         err_runt_q    <= err_runt_d;
      end
   end

   // The first pixel shifted in after a latch belongs to the highest column.
   assign wr.wr_valid                = (state_q == EMIT);
   assign wr.wr_row                  = row_q;
   assign wr.wr_column               = col_q;
   assign wr.wr_plane                = plane_q;
   assign {wr.wr_rgb1, wr.wr_rgb2}   = hold_q[COL_LAST - col_q];
   assign err_count                  = err_count_q;
   assign err_overrun                = err_overrun_q;
   assign err_runt                   = err_runt_q;

endmodule

// File: tb/tb_matrix_capture.sv
// Directed bench for matrix_capture: a unit-width instance and a 4x
// oversampled instance share one HUB75 stimulus bus; every handshake is
// recorded and compared against hand-computed rows.
module tb_matrix_capture;

   typedef struct packed {
      logic [3:0] row;
      logic [5:0] col;
      logic [2:0] plane;
      logic [2:0] rgb1;
      logic [2:0] rgb2;
   } wr_rec_t;

   logic       clk_in = 1'b0;
   logic       rst_n = 1'b0;
   logic       hub_clk = 1'b0, hub_latch = 1'b0, hub_oe = 1'b0;
   logic [3:0] hub_addr = '0;
   logic [2:0] hub_rgb1 = '0, hub_rgb2 = '0;
   logic       clear_err = 1'b0;
   logic       err_count, err_overrun, err_runt;
   logic       err2_count, err2_overrun, err2_runt;

   int assertions = 0;
   int failures   = 0;
   int bad;

   wr_rec_t wq[$];
   wr_rec_t wq2[$];

   matrix_capture_if bus ();
   matrix_capture_if bus2 ();

   assign bus2.wr_ready = 1'b1;

   always #5 clk_in = ~clk_in;

   matrix_capture #(.COLUMNS(64), .PLANES(6), .OE_UNIT_LOG2(0)) dut (
      .clk_in(clk_in), .reset(rst_n),
      .hub_clk(hub_clk), .hub_latch(hub_latch), .hub_oe(hub_oe), .hub_addr(hub_addr),
      .hub_rgb1(hub_rgb1), .hub_rgb2(hub_rgb2),
      .wr(bus.master),
      .err_count(err_count), .err_overrun(err_overrun), .err_runt(err_runt),
      .clear_err(clear_err)
   );

   matrix_capture #(.COLUMNS(64), .PLANES(6), .OE_UNIT_LOG2(2)) dut2 (
      .clk_in(clk_in), .reset(rst_n),
      .hub_clk(hub_clk), .hub_latch(hub_latch), .hub_oe(hub_oe), .hub_addr(hub_addr),
      .hub_rgb1(hub_rgb1), .hub_rgb2(hub_rgb2),
      .wr(bus2.master),
      .err_count(err2_count), .err_overrun(err2_overrun), .err_runt(err2_runt),
      .clear_err(clear_err)
   );

   // Record every handshake, sampled mid-cycle where inputs and outputs are settled.
   always @(negedge clk_in) begin
      if (rst_n) begin
         if (bus.wr_valid && bus.wr_ready)
            wq.push_back(wr_rec_t'({bus.wr_row, bus.wr_column, bus.wr_plane, bus.wr_rgb1, bus.wr_rgb2}));
         if (bus2.wr_valid && bus2.wr_ready)
            wq2.push_back(wr_rec_t'({bus2.wr_row, bus2.wr_column, bus2.wr_plane, bus2.wr_rgb1, bus2.wr_rgb2}));
      end
   end

   // Hard stop if something hangs despite the per-wait budgets.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_in);
         #2;
      end
   endtask

   task automatic send_pixel(input logic [2:0] r1, input logic [2:0] r2);
      hub_rgb1 = r1;
      hub_rgb2 = r2;
      tick(2);
      hub_clk = 1'b1;
      tick(2);
      hub_clk = 1'b0;
   endtask

   // Sent pixel k carries rgb1 = k+seed, rgb2 = (k>>3)+seed (mod 8).
   task automatic send_row(input int n, input int seed);
      for (int k = 0; k < n; k++) send_pixel(3'(k + seed), 3'((k >> 3) + seed));
   endtask

   task automatic latch_row(input logic [3:0] addr);
      hub_addr = addr;
      tick(1);
      hub_latch = 1'b1;
      tick(2);
      hub_latch = 1'b0;
      tick(2);
   endtask

   task automatic oe_pulse(input int width);
      hub_oe = 1'b1;
      tick(width);
      hub_oe = 1'b0;
      tick(4);
   endtask

   task automatic send_frame(input int seed, input logic [3:0] addr, input int width);
      send_row(64, seed);
      latch_row(addr);
      oe_pulse(width);
   endtask

   task automatic wait_writes(input bit second, input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if ((second ? wq2.size() : wq.size()) >= n) break;
         tick(1);
      end
      tick(2);
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && !bus.wr_valid; i++) tick(1);
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      tick(1);
   endtask

   // Reference row: column c holds sent pixel 63-c. Returns the number of
   // missing or mismatching records among the first 64.
   function automatic int row_bad(input bit second, input logic [3:0] row,
                                  input logic [2:0] plane, input int seed);
      int      n = 0;
      int      k;
      wr_rec_t got, exp;
      for (int i = 0; i < 64; i++) begin
         k   = 63 - i;
         exp = {row, 6'(i), plane, 3'(k + seed), 3'((k >> 3) + seed)};
         if (i >= (second ? wq2.size() : wq.size())) begin
            n++;
         end else begin
            got = second ? wq2[i] : wq[i];
            if (got !== exp) n++;
         end
      end
      return n;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      tick(3);
      assertions++;
      if ({bus.wr_valid, bus.wr_row, bus.wr_column, bus.wr_plane, bus.wr_rgb1, bus.wr_rgb2} !== 20'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %h, expected 0",
                  {bus.wr_valid, bus.wr_row, bus.wr_column, bus.wr_plane, bus.wr_rgb1, bus.wr_rgb2});
      end
      assertions++;
      if ({err_count, err_overrun, err_runt} !== 3'b000) begin
         failures++;
         $display("FAIL reset_errors: got %b, expected 000", {err_count, err_overrun, err_runt});
      end
      rst_n = 1'b1;
      tick(3);
   endtask

   task automatic test_basic_row();
      wq.delete();
      send_frame(0, 4'd5, 16);
      wait_writes(1'b0, 64, 400);
      assertions++;
      if (wq.size() !== 64) begin
         failures++;
         $display("FAIL basic_count: got %0d writes, expected 64", wq.size());
      end
      bad = row_bad(1'b0, 4'd5, 3'd3, 0);
      assertions++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL basic_row: got %0d bad records, expected 0", bad);
      end
      assertions++;
      if (wq.size() < 64 || {wq[0].col, wq[0].rgb1, wq[63].col, wq[63].rgb1} !== {6'd0, 3'd7, 6'd63, 3'd0}) begin
         failures++;
         $display("FAIL basic_ends: got %0d writes / first,last col-rgb1 mismatch, expected col0=7 col63=0", wq.size());
      end
   endtask

   task automatic test_planes();
      int widths [6] = '{64, 32, 16, 8, 4, 2};
      for (int i = 0; i < 6; i++) begin
         wq.delete();
         send_frame(i + 1, 4'(i), widths[i]);
         wait_writes(1'b0, 64, 400);
         bad = row_bad(1'b0, 4'(i), 3'(5 - i), i + 1);
         assertions++;
         if (bad !== 0 || wq.size() !== 64) begin
            failures++;
            $display("FAIL plane_width_%0d: got %0d writes, %0d bad, expected 64 writes, 0 bad",
                     widths[i], wq.size(), bad);
         end
      end
      assertions++;
      if ({err_count, err_overrun, err_runt} !== 3'b000) begin
         failures++;
         $display("FAIL plane_errors: got %b, expected 000", {err_count, err_overrun, err_runt});
      end
   endtask

   task automatic test_count_error();
      wq.delete();
      send_row(63, 2);
      latch_row(4'd6);
      tick(2);
      assertions++;
      if (err_count !== 1'b1) begin
         failures++;
         $display("FAIL count_err_set: got %b, expected 1", err_count);
      end
      oe_pulse(16);
      tick(100);
      assertions++;
      if (wq.size() !== 0) begin
         failures++;
         $display("FAIL count_err_dropped: got %0d writes, expected 0", wq.size());
      end
      pulse_clear();
      assertions++;
      if (err_count !== 1'b0) begin
         failures++;
         $display("FAIL count_err_clear: got %b, expected 0", err_count);
      end
      send_frame(3, 4'd7, 8);
      wait_writes(1'b0, 64, 400);
      bad = row_bad(1'b0, 4'd7, 3'd2, 3);
      assertions++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL count_err_recover: got %0d bad records, expected 0", bad);
      end
   endtask

   task automatic test_overrun();
      bus.wr_ready = 1'b0;
      wq.delete();
      send_frame(4, 4'd3, 32);
      wait_valid(100);
      // Column 0 is pixel 63: rgb1 = (63+4)%8 = 3, rgb2 = (7+4)%8 = 3, plane 4.
      assertions++;
      if ({bus.wr_valid, bus.wr_row, bus.wr_column, bus.wr_plane, bus.wr_rgb1, bus.wr_rgb2}
          !== {1'b1, 4'd3, 6'd0, 3'd4, 3'd3, 3'd3}) begin
         failures++;
         $display("FAIL overrun_stall_head: got %h, expected %h",
                  {bus.wr_valid, bus.wr_row, bus.wr_column, bus.wr_plane, bus.wr_rgb1, bus.wr_rgb2},
                  {1'b1, 4'd3, 6'd0, 3'd4, 3'd3, 3'd3});
      end
      send_row(64, 5);
      latch_row(4'd4);
      tick(2);
      assertions++;
      if (err_overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_set: got %b, expected 1", err_overrun);
      end
      assertions++;
      if ({bus.wr_valid, bus.wr_row, bus.wr_column, bus.wr_plane, bus.wr_rgb1, bus.wr_rgb2}
          !== {1'b1, 4'd3, 6'd0, 3'd4, 3'd3, 3'd3} || wq.size() !== 0) begin
         failures++;
         $display("FAIL overrun_stable: got %h with %0d writes, expected %h with 0",
                  {bus.wr_valid, bus.wr_row, bus.wr_column, bus.wr_plane, bus.wr_rgb1, bus.wr_rgb2},
                  wq.size(), {1'b1, 4'd3, 6'd0, 3'd4, 3'd3, 3'd3});
      end
      bus.wr_ready = 1'b1;
      wait_writes(1'b0, 64, 400);
      bad = row_bad(1'b0, 4'd3, 3'd4, 4);
      assertions++;
      if (bad !== 0 || wq.size() !== 64) begin
         failures++;
         $display("FAIL overrun_first_row: got %0d writes, %0d bad, expected 64, 0", wq.size(), bad);
      end
      pulse_clear();
   endtask

   task automatic test_runt_and_units();
      wq.delete();
      send_frame(6, 4'd2, 1);
      tick(20);
      assertions++;
      if (err_runt !== 1'b1 || wq.size() !== 0) begin
         failures++;
         $display("FAIL runt: got err_runt=%b with %0d writes, expected 1 with 0", err_runt, wq.size());
      end
      pulse_clear();
      wq.delete();
      wq2.delete();
      send_frame(7, 4'd10, 64);
      wait_writes(1'b0, 64, 400);
      wait_writes(1'b1, 64, 400);
      bad = row_bad(1'b0, 4'd10, 3'd5, 7);
      assertions++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL runt_recover: got %0d bad records, expected 0", bad);
      end
      bad = row_bad(1'b1, 4'd10, 3'd3, 7);
      assertions++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL oversample_plane: got %0d bad records, expected 0", bad);
      end
      pulse_clear();
   endtask

   task automatic test_reset_mid_emit();
      bus.wr_ready = 1'b0;
      wq.delete();
      send_frame(1, 4'd12, 16);
      wait_valid(100);
      bus.wr_ready = 1'b1;
      tick(20);
      bus.wr_ready = 1'b0;
      tick(1);
      assertions++;
      if (wq.size() !== 20 || bus.wr_column !== 6'd20 || bus.wr_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_emit_position: got %0d writes col %0d valid %b, expected 20 col 20 valid 1",
                  wq.size(), bus.wr_column, bus.wr_valid);
      end
      #1;
      rst_n = 1'b0;
      #1;
      assertions++;
      if ({bus.wr_valid, bus.wr_row, bus.wr_column, bus.wr_plane, bus.wr_rgb1, bus.wr_rgb2} !== 20'h0) begin
         failures++;
         $display("FAIL mid_emit_reset: got %h, expected 0",
                  {bus.wr_valid, bus.wr_row, bus.wr_column, bus.wr_plane, bus.wr_rgb1, bus.wr_rgb2});
      end
      tick(2);
      rst_n = 1'b1;
      bus.wr_ready = 1'b1;
      tick(2);
      wq.delete();
      send_frame(2, 4'd9, 16);
      wait_writes(1'b0, 64, 400);
      bad = row_bad(1'b0, 4'd9, 3'd3, 2);
      assertions++;
      if (bad !== 0 || wq.size() !== 64) begin
         failures++;
         $display("FAIL post_reset_row: got %0d writes, %0d bad, expected 64, 0", wq.size(), bad);
      end
      assertions++;
      if ({err_count, err_overrun, err_runt} !== 3'b000) begin
         failures++;
         $display("FAIL post_reset_errors: got %b, expected 000", {err_count, err_overrun, err_runt});
      end
   endtask

   initial begin
      bus.wr_ready = 1'b1;
      test_reset();
      test_basic_row();
      test_planes();
      test_count_error();
      test_overrun();
      test_runt_and_units();
      test_reset_mid_emit();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
